axis_i2c_slave: RTL
===================

// Module: axis_i2c_slave
// PURPOSE
//  I2C target (slave) with AXI-Stream data ports; the responder counterpart of axis_i2c_master.
//  Oversamples SCL/SDA in the system clock domain, detects START/STOP and matches a 7-bit address.
//  Write bytes from the bus are presented on m_axis; bytes for bus reads are taken from s_axis.
//  Used as on-chip peripheral model and as loopback target for master bring-up. No clock stretching.
// PARAMETERS
//  DATA_WIDTH   8      byte width on bus and on both axis_if ports (fixed at 8 for I2C)
//  SLAVE_ADDR   7'h3C  7-bit address this target responds to
//  IDLE_BYTE    8'hFF  byte returned on read when s_axis has no valid data
// PORTS
//  clk_i       in     1   system clock; must be >= 16x SCL frequency
//  arstn_i     in     1   synchronous active-low reset
//  i2c_scl_i   in     1   SCL from bus (input only; target never drives SCL)
//  i2c_sda_io  inout  1   SDA, open-drain: 1'b0 when sda_oe, else 1'bz
//  s_axis      slave  axis_if(DATA_WIDTH)  tx bytes for master reads (tdata/tvalid/tready)
//  m_axis      master axis_if(DATA_WIDTH)  rx bytes from master writes (tdata/tvalid/tready)
//  busy_o      out    1   high from addressed START until STOP/unmatched
//  overrun_o   out    1   one-cycle pulse when a write byte was NACKed because m_axis still full
// BEHAVIOUR
//  Reset (arstn_i=0 at clk_i edge): state IDLE, sda_oe=0, m_axis.tvalid=0, s_axis.tready=0, busy_o=0,
//   overrun_o=0, shift regs 0. Reset mid-transfer releases SDA on the next clock edge.
//  Input path: 2-flop sync per line, then edge detect -> scl_rise/scl_fall/sda_rise/sda_fall; 3-cycle latency.
//  START = sda_fall while SCL high; STOP = sda_rise while SCL high. Both take priority over bit events.
//  START from any state (repeated start) -> ADDR, bit cnt 0, sda_oe=0. STOP from any state -> IDLE, busy_o=0.
//  Sample SDA on scl_rise; change sda_oe only on scl_fall. MSB first.
//  States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
//  ADDR: shift 8 bits; on 8th scl_fall: addr==SLAVE_ADDR -> sda_oe=1, ADDR_ACK, busy_o=1; else IGNORE.
//  ADDR_ACK: on 9th scl_fall: R/W=0 -> release, WR_DATA; R/W=1 -> load tx byte, drive MSB, RD_DATA.
//  Tx load: s_axis.tvalid=1 -> take tdata, s_axis.tready high exactly 1 cycle; else IDLE_BYTE, no tready.
//  WR_DATA: 8 bits; on 8th scl_fall: m_axis.tvalid=0 -> tdata<=byte, tvalid<=1, sda_oe=1 (ACK), WR_ACK;
//   tvalid=1 -> sda_oe=0 (NACK), byte dropped, overrun_o pulse, WR_ACK. On 9th scl_fall release -> WR_DATA.
//  m_axis.tvalid holds until tvalid&tready; tdata stable while valid; STOP/START do not clear it.
//  RD_DATA: sda_oe = ~tx_bit; after 8th scl_fall release SDA -> RD_ACK.
//  RD_ACK: sample on scl_rise; ACK(0) -> on scl_fall load next byte, RD_DATA; NACK(1) -> IGNORE.
//  IGNORE: SDA released, only START/STOP recognised. Bit counter 0..8 wraps to 0 on each byte boundary.
// CONFIGURATION
//  I2C_SLAVE_GLITCH_FILTER_EN defined: 3-tap majority filter after the synchronizers on SCL and SDA;
//   pulses <= 1 clk_i ignored; input latency becomes 5 cycles.
//  Not defined: synchronizer output used directly; 3-cycle latency; glitches act as edges.
// STRUCTURE
//  Package i2c_slave_pkg: state_t enum, ACK=1'b0/NACK=1'b1, BIT_CNT_W=4, BYTE_BITS=8.
//  Sub-module i2c_line_sync: sync + optional filter + rise/fall detect; instanced for SCL and SDA.
//  Top holds FSM, shift regs, axis handshakes, open-drain assign.
// TESTING
//  1 Write: START, 0x78 (0x3C,W), 0xA5, 0x5A, STOP, m_axis.tready=1 -> 3 ACKs; m_axis emits 0xA5 then 0x5A.
//  2 Wrong addr 0x42 (0x21,W) + 0x11 -> SDA never pulled low, no m_axis transfer, busy_o stays 0.
//  3 Read: s_axis holds 0xC3, START, 0x79, master ACK then NACK -> SDA bits 11000011, then 0xFF; one tready pulse.
//  4 m_axis.tready=0, write 0x01,0x02 -> 0x01 ACKed and held, 0x02 NACKed, overrun_o 1-cycle pulse.
//  5 Repeated START after 4 bits of data byte, new 0x79 -> FSM back in ADDR, read proceeds, no partial byte out.
//  6 arstn_i=0 during RD_DATA with SDA driven low -> sda_oe=0 next edge, state IDLE; with filter macro a
//    1-cycle SCL glitch in WR_DATA causes no extra bit shifted.

Source files
------------

// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C target: FSM states, bus ACK levels,
// bit-counter geometry and the majority-vote helper used by the input filter.
package i2c_slave_pkg;

  localparam int BIT_CNT_W = 4;
  localparam int BYTE_BITS = 8;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  localparam logic [BIT_CNT_W-1:0] CNT_ZERO = 4'd0;
  localparam logic [BIT_CNT_W-1:0] CNT_ONE  = 4'd1;
  localparam logic [BIT_CNT_W-1:0] CNT_BYTE = 4'd8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    WR_DATA  = 3'd3,
    WR_ACK   = 3'd4,
    RD_DATA  = 3'd5,
    RD_ACK   = 3'd6,
    IGNORE   = 3'd7
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Brings one I2C line into the clk domain: 2-flop synchronizer, optional 3-tap
// majority filter (I2C_SLAVE_GLITCH_FILTER_EN), then registered rise/fall detect.
module i2c_line_sync (
  input  logic clk,
  input  logic arstn,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);
  import i2c_slave_pkg::*;

  logic sync0_r;
  logic sync1_r;
  logic level_s;
  logic prev_r;
  logic rise_r;
  logic fall_r;

  // Metastability synchronizer; lines idle high so reset to 1 avoids a false edge
  always_ff @(posedge clk) begin
    if (!arstn) begin
      sync0_r <= 1'b1;
      sync1_r <= 1'b1;
    end else begin
      sync0_r <= raw;
      sync1_r <= sync0_r;
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic tap0_r;
  logic tap1_r;
  logic maj_r;

  // Majority vote over three consecutive samples suppresses single-cycle pulses
  always_ff @(posedge clk) begin
    if (!arstn) begin
      tap0_r <= 1'b1;
      tap1_r <= 1'b1;
      maj_r  <= 1'b1;
    end else begin
      tap0_r <= sync1_r;
      tap1_r <= tap0_r;
      maj_r  <= maj3(sync1_r, tap0_r, tap1_r);
    end
  end

  assign level_s = maj_r;
`else
  assign level_s = sync1_r;
`endif

  // Edge detect; level is delayed to stay aligned with the registered edge pulses
  always_ff @(posedge clk) begin
    if (!arstn) begin
      prev_r <= 1'b1;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      prev_r <= level_s;
      rise_r <= level_s & ~prev_r;
      fall_r <= ~level_s & prev_r;
    end
  end

  assign level = prev_r;
  assign rise  = rise_r;
  assign fall  = fall_r;

endmodule

// File: rtl/axis_i2c_slave.sv
// I2C target with AXI-Stream byte ports; no clock stretching. Define
// I2C_SLAVE_GLITCH_FILTER_EN to enable the majority filter on SCL/SDA inputs.
module axis_i2c_slave #(
  parameter int                    DATA_WIDTH = 8,
  parameter logic [6:0]            SLAVE_ADDR = 7'h3C,
  parameter logic [DATA_WIDTH-1:0] IDLE_BYTE  = 8'hFF
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic                  i2c_scl_i,
  inout  wire                   i2c_sda_io,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  busy_o,
  output logic                  overrun_o
);
  import i2c_slave_pkg::*;

  logic scl_s, scl_rise_s, scl_fall_s;
  logic sda_s, sda_rise_s, sda_fall_s;
  logic start_s, stop_s;
  logic [DATA_WIDTH-1:0] tx_load_s;

  state_t                state_r, state_n;
  logic [BIT_CNT_W-1:0]  bit_cnt_r, bit_cnt_n;
  logic [DATA_WIDTH-1:0] shift_r, shift_n;
  logic [DATA_WIDTH-1:0] tx_r, tx_n;
  logic [DATA_WIDTH-1:0] m_tdata_r, m_tdata_n;
  logic rw_r, rw_n;
  logic mack_r, mack_n;
  logic sda_oe_r, sda_oe_n;
  logic busy_r, busy_n;
  logic overrun_r, overrun_n;
  logic s_tready_r, s_tready_n;
  logic m_tvalid_r, m_tvalid_n;

  i2c_line_sync u_scl_sync (
    .clk   (clk_i),
    .arstn (arstn_i),
    .raw   (i2c_scl_i),
    .level (scl_s),
    .rise  (scl_rise_s),
    .fall  (scl_fall_s)
  );

  i2c_line_sync u_sda_sync (
    .clk   (clk_i),
    .arstn (arstn_i),
    .raw   (i2c_sda_io),
    .level (sda_s),
    .rise  (sda_rise_s),
    .fall  (sda_fall_s)
  );

  assign start_s   = sda_fall_s & scl_s;
  assign stop_s    = sda_rise_s & scl_s;
  assign tx_load_s = s_axis_tvalid ? s_axis_tdata : IDLE_BYTE;

  // Next-state and datapath decode; bus conditions override bit-level events
  always_comb begin
    state_n    = state_r;
    bit_cnt_n  = bit_cnt_r;
    shift_n    = shift_r;
    tx_n       = tx_r;
    rw_n       = rw_r;
    mack_n     = mack_r;
    sda_oe_n   = sda_oe_r;
    busy_n     = busy_r;
    overrun_n  = 1'b0;
    s_tready_n = 1'b0;
    m_tdata_n  = m_tdata_r;
    if (m_tvalid_r && m_axis_tready) begin
      m_tvalid_n = 1'b0;
    end else begin
      m_tvalid_n = m_tvalid_r;
    end

    if (start_s) begin
      state_n   = ADDR;
      bit_cnt_n = CNT_ZERO;
      shift_n   = '0;
      sda_oe_n  = 1'b0;
    end else if (stop_s) begin
      state_n   = IDLE;
      bit_cnt_n = CNT_ZERO;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
    end else begin
      case (state_r)
        ADDR, WR_DATA: begin
          if (scl_rise_s) begin
            shift_n   = {shift_r[DATA_WIDTH-2:0], sda_s};
            bit_cnt_n = bit_cnt_r + CNT_ONE;
          end else if (scl_fall_s && (bit_cnt_r == CNT_BYTE)) begin
            bit_cnt_n = CNT_ZERO;
            if (state_r == ADDR) begin
              if (shift_r[DATA_WIDTH-1:1] == SLAVE_ADDR) begin
                rw_n     = shift_r[0];
                sda_oe_n = 1'b1;
                busy_n   = 1'b1;
                state_n  = ADDR_ACK;
              end else begin
                busy_n  = 1'b0;
                state_n = IGNORE;
              end
            end else begin
              state_n = WR_ACK;
              // A still-pending m_axis byte means this one cannot be stored: NACK it
              if (!m_tvalid_r) begin
                m_tdata_n  = shift_r;
                m_tvalid_n = 1'b1;
                sda_oe_n   = 1'b1;
              end else begin
                sda_oe_n  = 1'b0;
                overrun_n = 1'b1;
              end
            end
          end else begin
            bit_cnt_n = bit_cnt_r;
          end
        end
        ADDR_ACK: begin
          if (scl_fall_s) begin
            bit_cnt_n = CNT_ZERO;
            if (rw_r) begin
              tx_n       = tx_load_s;
              s_tready_n = s_axis_tvalid;
              sda_oe_n   = ~tx_load_s[DATA_WIDTH-1];
              state_n    = RD_DATA;
            end else begin
              sda_oe_n = 1'b0;
              state_n  = WR_DATA;
            end
          end else begin
            state_n = ADDR_ACK;
          end
        end
        WR_ACK: begin
          if (scl_fall_s) begin
            sda_oe_n  = 1'b0;
            bit_cnt_n = CNT_ZERO;
            state_n   = WR_DATA;
          end else begin
            state_n = WR_ACK;
          end
        end
        RD_DATA: begin
          if (scl_rise_s) begin
            bit_cnt_n = bit_cnt_r + CNT_ONE;
          end else if (scl_fall_s && (bit_cnt_r == CNT_BYTE)) begin
            bit_cnt_n = CNT_ZERO;
            sda_oe_n  = 1'b0;
            state_n   = RD_ACK;
          end else if (scl_fall_s) begin
            tx_n     = {tx_r[DATA_WIDTH-2:0], 1'b0};
            sda_oe_n = ~tx_r[DATA_WIDTH-2];
          end else begin
            bit_cnt_n = bit_cnt_r;
          end
        end
        RD_ACK: begin
          if (scl_rise_s) begin
            mack_n = sda_s;
          end else if (scl_fall_s && (mack_r == ACK)) begin
            tx_n       = tx_load_s;
            s_tready_n = s_axis_tvalid;
            sda_oe_n   = ~tx_load_s[DATA_WIDTH-1];
            bit_cnt_n  = CNT_ZERO;
            state_n    = RD_DATA;
          end else if (scl_fall_s) begin
            sda_oe_n = 1'b0;
            state_n  = IGNORE;
          end else begin
            mack_n = mack_r;
          end
        end
        IDLE, IGNORE: begin
          sda_oe_n = 1'b0;
        end
        default: begin
          state_n  = IDLE;
          sda_oe_n = 1'b0;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      state_r    <= IDLE;
      bit_cnt_r  <= CNT_ZERO;
      shift_r    <= '0;
      tx_r       <= '0;
      m_tdata_r  <= '0;
      rw_r       <= 1'b0;
      mack_r     <= 1'b1;
      sda_oe_r   <= 1'b0;
      busy_r     <= 1'b0;
      overrun_r  <= 1'b0;
      s_tready_r <= 1'b0;
      m_tvalid_r <= 1'b0;
    end else begin
      state_r    <= state_n;
      bit_cnt_r  <= bit_cnt_n;
      shift_r    <= shift_n;
      tx_r       <= tx_n;
      m_tdata_r  <= m_tdata_n;
      rw_r       <= rw_n;
      mack_r     <= mack_n;
      sda_oe_r   <= sda_oe_n;
      busy_r     <= busy_n;
      overrun_r  <= overrun_n;
      s_tready_r <= s_tready_n;
      m_tvalid_r <= m_tvalid_n;
    end
  end

  assign i2c_sda_io    = sda_oe_r ? 1'b0 : 1'bz;
  assign s_axis_tready = s_tready_r;
  assign m_axis_tdata  = m_tdata_r;
  assign m_axis_tvalid = m_tvalid_r;
  assign busy_o        = busy_r;
  assign overrun_o     = overrun_r;

endmodule
